// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: sign-magnitude add/sub/mul/div, iterating mul and div one bit per cycle.
// Define CALC_SEQ_REMAINDER_EN to add the o_remainder output for division.
module calc_op_sequencer #(
  parameter int WIDTH = 40,
  parameter longint MAX_VAL = 999999
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_arith_func,
  input  logic [WIDTH-1:0] i_s1,
  input  logic [WIDTH-1:0] i_s2,
  input  logic             i_sign1,
  input  logic             i_sign2,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_sign,
  output logic             o_err
`ifdef CALC_SEQ_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] o_remainder
`endif
);
  localparam int MW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
  logic [1:0] state, fn;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a, b, rem;
  logic [MW-1:0] acc, mag;
  logic [WIDTH:0] addmag, mulsum, sh, trial;
  logic sg1, sg2, rs, dz, eff2, same, ge, fits, err, last;
  always_comb begin
    eff2 = sg2 ^ (fn == 2'b01);
    same = sg1 == eff2;
    ge = a >= b;
    addmag = same ? {1'b0, a} + {1'b0, b} : {1'b0, ge ? a - b : b - a};
    mulsum = {1'b0, acc[MW-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
    sh = {rem, a[WIDTH-1]};
    trial = sh - {1'b0, b};
    fits = !trial[WIDTH];
    mag = fn == 2'b11 ? MW'(a) : acc;
    err = dz || mag > MW'(MAX_VAL);
    last = cnt == CW'(WIDTH - 1);
  end
  // mul: acc low half holds the multiplier, shifted out as the product shifts in
  // div: a holds the dividend, shifted out as quotient bits shift in
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      fn <= '0;
      cnt <= '0;
      a <= '0;
      b <= '0;
      rem <= '0;
      acc <= '0;
      sg1 <= 1'b0;
      sg2 <= 1'b0;
      rs <= 1'b0;
      dz <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_result <= '0;
      o_sign <= 1'b0;
      o_err <= 1'b0;
`ifdef CALC_SEQ_REMAINDER_EN
      o_remainder <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          fn <= i_arith_func;
          a <= i_s1;
          b <= i_s2;
          sg1 <= i_sign1;
          sg2 <= i_sign2;
          acc <= MW'(i_s1);
          rem <= '0;
          cnt <= '0;
          dz <= 1'b0;
          o_err <= 1'b0;
          o_busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!fn[1]) begin
            acc <= MW'(addmag);
            rs <= (same || ge) ? sg1 : eff2;
            state <= FIN;
          end else if (!fn[0]) begin
            acc <= {mulsum, acc[WIDTH-1:1]};
            rs <= sg1 ^ sg2;
            state <= last ? FIN : RUN;
          end else if (b == '0) begin
            dz <= 1'b1;
            state <= FIN;
          end else begin
            rem <= fits ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
            a <= {a[WIDTH-2:0], fits};
            rs <= sg1 ^ sg2;
            state <= last ? FIN : RUN;
          end
        end
        FIN: begin
          o_result <= err ? '0 : mag[WIDTH-1:0];
          o_sign <= !err && rs && mag != '0;
          o_err <= err;
          o_done <= 1'b1;
          o_busy <= 1'b0;
`ifdef CALC_SEQ_REMAINDER_EN
          o_remainder <= (err || fn != 2'b11) ? '0 : rem;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: scoreboard bench with an arithmetic reference model and randomized operations.
module tb_calc_op_sequencer;
  localparam int W = 40;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, s1g = 1'b0, s2g = 1'b0;
  logic [1:0] func = '0;
  logic [W-1:0] s1 = '0, s2 = '0;
  logic busy, done, sign, err;
  logic [W-1:0] result;
`ifdef CALC_SEQ_REMAINDER_EN
  logic [W-1:0] remainder;
`endif
  calc_op_sequencer dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_arith_func(func),
    .i_s1(s1), .i_s2(s2), .i_sign1(s1g), .i_sign2(s2g),
    .o_busy(busy), .o_done(done), .o_result(result), .o_sign(sign), .o_err(err)
`ifdef CALC_SEQ_REMAINDER_EN
    , .o_remainder(remainder)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] res;
    logic sg;
    logic er;
    logic [W-1:0] rm;
    int lat;
    int cap;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(int f, logic [W-1:0] a, logic ga, logic [W-1:0] b, logic gb, int cap);
    exp_t e;
    longint v;
    logic [127:0] m;
    logic er;
    er = 1'b0;
    e.rm = '0;
    e.sg = 1'b0;
    e.cap = cap;
    e.lat = W + 1;
    if (f < 2) begin
      v = (ga ? -longint'(a) : longint'(a)) + (((f == 1) ^ gb) ? -longint'(b) : longint'(b));
      m = 128'(v < 0 ? -v : v);
      e.sg = v < 0;
      e.lat = 2;
    end else if (f == 2) begin
      m = 128'(a) * 128'(b);
      e.sg = ga ^ gb;
    end else if (b == 0) begin
      m = '0;
      er = 1'b1;
      e.lat = 2;
    end else begin
      m = 128'(a / b);
      e.rm = a % b;
      e.sg = ga ^ gb;
    end
    if (m > 999999) er = 1'b1;
    e.er = er;
    e.res = er ? '0 : m[W-1:0];
    if (er || m == 0) e.sg = 1'b0;
    if (er) e.rm = '0;
    return e;
  endfunction
  always @(negedge clk) if (done) begin
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL spurious_done: got done=1 expected no done (cycle %0d)", cyc);
    end else begin
      exp_t e;
      e = q.pop_front();
      chk("result", result, e.res);
      chk("sign", sign, e.sg);
      chk("err", err, e.er);
      chk("latency", cyc - e.cap, e.lat);
      chk("busy_at_done", busy, 0);
`ifdef CALC_SEQ_REMAINDER_EN
      chk("remainder", remainder, e.rm);
`endif
    end
  end
  task automatic do_op(int f, logic [W-1:0] a, logic ga, logic [W-1:0] b, logic gb, bit push);
    @(negedge clk);
    func = 2'(f);
    s1 = a;
    s2 = b;
    s1g = ga;
    s2g = gb;
    start = 1'b1;
    if (push) q.push_back(model(f, a, ga, b, gb, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    if (push) chk("busy_after_start", busy, 1);
    s1 = 40'({$urandom, $urandom});
    s2 = 40'({$urandom, $urandom});
    func = 2'($urandom);
    s1g = 1'($urandom);
    s2g = 1'($urandom);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
      q.delete();
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_sign", sign, 0);
    chk("reset_err", err, 0);
    rst = 1'b0;
    do_op(0, 123, 0, 200, 1, 1); wait_idle();
    do_op(1, 5, 0, 5, 0, 1); wait_idle();
    do_op(2, 999, 0, 1001, 0, 1); wait_idle();
    do_op(2, 1000, 0, 1000, 1, 1); wait_idle();
    do_op(3, 100, 1, 7, 0, 1); wait_idle();
    do_op(3, 5, 0, 0, 0, 1); wait_idle();
    do_op(0, 1, 0, 2, 0, 1);
    @(negedge clk);
    do_op(1, 3, 1, 9, 1, 1); wait_idle();
    do_op(2, 123, 1, 456, 0, 1);
    repeat (8) @(negedge clk);
    do_op(0, 7, 0, 8, 0, 0);
    wait_idle();
    do_op(3, 999999, 0, 3, 0, 1);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    #1;
    chk("reset_mid_busy", busy, 0);
    chk("reset_mid_done", done, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("reset_wins_busy", busy, 0);
    repeat (45) @(negedge clk);
    do_op(0, 3, 0, 4, 0, 1); wait_idle();
    for (int n = 0; n < 40; n++) begin
      int f;
      logic [W-1:0] a, b;
      f = $urandom_range(0, 3);
      a = f == 2 ? 40'($urandom_range(0, 1500)) : f == 3 ? 40'($urandom_range(0, 2000000)) : 40'($urandom_range(0, 999999));
      b = f == 2 ? 40'($urandom_range(0, 1500)) : f == 3 ? 40'($urandom_range(0, 3000)) : 40'($urandom_range(0, 999999));
      if ($urandom_range(0, 9) == 0) a = 40'({$urandom, $urandom});
      if (f == 3 && $urandom_range(0, 7) == 0) b = '0;
      do_op(f, a, 1'($urandom), b, 1'($urandom), 1);
      wait_idle();
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
